wb_stage: RTL and testbench
===========================

# wb_stage

Write-back stage of the five-stage LC-3 pipeline, directly downstream of the memory-access stage. Each cycle it consumes that stage's registered outputs (instruction, next PC, data word, PSR image, PC redirect) and retires the instruction. Retiring means updating the 8×16 general register file, the NZP condition codes, the PSR, and a retire counter. It also supplies register operands to decode through two read ports with write-through bypass.

## Interface
- `RF_INIT`, 16'h0000: reset value of R0–R7.
- `PSR_INIT`, 16'h8002: reset PSR; bits [2:0] are the reset CC (Z=1).
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low; asserted (0) clears all state immediately.
- `wbIRin` in 16: instruction from memory stage; 16'h9000 = bubble/NOP.
- `wbNPCin` in 16: PC+1 of that instruction.
- `wbData` in 16: result word (ALU result, load data, or RTI restored SP).
- `wbPCin` in 16: redirect target (TRAP vector / RTI return PC).
- `wbCond` in 1: redirect request qualifier.
- `wbPSRin` in 16: PSR image for RTI second cycle.
- `wbValid` in 1: 0 while the memory stage is in an indirect/RTI pause cycle whose data is not final.
- `idSR1`, `idSR2` in 3: decode read addresses.
- `idSR1data`, `idSR2data` out 16: read data (combinational, bypassed).
- `wbN`, `wbZ`, `wbP` out 1: current condition codes.
- `wbPSR` out 16: {psr[15:3], N, Z, P}.
- `wbRedirect` out 1: registered one-cycle redirect pulse.
- `wbTarget` out 16: registered redirect target.
- `wbInstret` out 16: retired-instruction count.

## Operation
- An instruction retires on a rising edge when `wbValid`=1 and `wbIRin`≠16'h9000. Bubbles and pause cycles change no architectural state.
- Retirement actions are decoded from `wbIRin[15:12]`, with DR = `wbIRin[11:9]`:
  - 0001 ADD, 0101 AND: DR←wbData; CC from wbData.
  - 1001 NOT/LS/RS/RSS/DPS: DR←wbData; CC from wbData. Exceptions in the same opcode: `[5:0]`=6'b100010 is WPS (PSR←wbData, CC←wbData[2:0], no register write); `[5:0]`=0 is NOP (no effect).
  - 0010 LD, 0110 LDR, 1010 LDI: DR←wbData; CC from wbData.
  - 1110 LEA: DR←wbData; CC unchanged.
  - 0100 JSR/JSRR: R7←wbNPCin.
  - 1111 TRAP: R7←wbNPCin; redirect to wbPCin.
  - 1000 RTI: first beat has `wbCond`=1 (redirect to wbPCin, no register write). Second beat has `wbCond`=0 (R6←wbData, PSR←wbPSRin, CC←wbPSRin[2:0]).
  - 0000 BR, 0011/0111/1011 stores, 1100 JMP: no register or CC effect.
- CC from a value v: N=v[15], Z=(v==0), P=!v[15]&&(v!=0). Exactly one of N/Z/P is set after any CC update.
- Redirect: `wbRedirect`←(retire && wbCond && op∈{TRAP,RTI}) and `wbTarget`←wbPCin, updated every edge. The pulse never stretches beyond one cycle, even if `wbCond` stays high.
- `wbInstret` increments by 1 per retirement and wraps 16'hFFFF→0. Each RTI beat with `wbValid`=1 counts separately.
- Read ports: if idSRx equals the register being written this cycle, the port returns the write value; otherwise it returns the stored value. R7 written by TRAP/JSR also bypasses.

## Timing
- Reset values: R0–R7=RF_INIT; CC=PSR_INIT[2:0] (N=0, Z=1, P=0); wbPSR=PSR_INIT; wbRedirect=0; wbTarget=0; wbInstret=0.
- Latency: register, CC, PSR and count updates are visible one edge after retirement. Read ports see the value the same cycle through the bypass.
- `wbValid`=0 blocks every update, including redirect and count.
- Reset asserted mid-instruction: all state returns to reset values asynchronously. After release, the next edge behaves normally; no partial RTI state is kept.
- There is only one write port, so simultaneous register writes cannot occur. WPS/RTI PSR load and CC-from-data never coincide.

## Structure
- Shared package `lc3_pkg`: opcode constants, NOP encoding 16'h9000, WPS/NOP function codes, PSR_INIT default, CC-from-value function.
- Sub-module `wb_regfile`: 8×16, one synchronous write port, two combinational read ports with write-through bypass, async active-low reset.
- Top-level logic: decode, CC/PSR registers, redirect register, retire counter.

## Test plan
- Reset release → all registers 0, CC=010, wbPSR=16'h8002, wbInstret=0, wbRedirect=0.
- ADD R3 (IR=16'h1642), wbData=16'hFFFE, valid → R3=FFFE, N=1, instret=1. Same cycle, idSR1=3 reads FFFE via bypass.
- LDI (IR=16'hA5xx): first beat valid=0 with wbData=1234 → no change. Second beat valid=1 with wbData=0 → R2=0, Z=1.
- TRAP x25 (IR=16'hF025), NPC=3001, PC=0520, cond=1, held 2 cycles with a NOP between → R7=3001, wbRedirect high exactly one cycle with wbTarget=0520.
- RTI: beat 1 (cond=1, PC=4000) → redirect to 4000. Beat 2 (cond=0, wbData=3000, wbPSRin=0x0001) → R6=3000, wbPSR=0001, P=1, instret +2.
- instret preloaded to FFFF by 65535 retirements, plus one more → 0000. Assert reset mid-RTI between beats → all state returns to reset values.

Source files
------------

// File: rtl/lc3_pkg.sv
// lc3_pkg: shared LC-3 opcodes, encodings and condition-code helper
package lc3_pkg;
  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;
  localparam logic [15:0] NOP_IR = 16'h9000;
  localparam logic [5:0] FN_WPS = 6'b100010;
  localparam logic [5:0] FN_NOP = 6'b000000;
  localparam logic [15:0] PSR_INIT_DEF = 16'h8002;

  // {N,Z,P} for a result value; exactly one bit is set
  function automatic logic [2:0] cc_of(input logic [15:0] v);
    return {v[15], v == 16'h0, !v[15] && (v != 16'h0)};
  endfunction
endpackage

// File: rtl/wb_regfile.sv
// wb_regfile: 8x16 register file, one write port, two bypassed read ports
module wb_regfile #(
  parameter logic [15:0] RF_INIT = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [2:0]  waddr,
  input  logic [15:0] wdata,
  input  logic [2:0]  ra1,
  input  logic [2:0]  ra2,
  output logic [15:0] rd1,
  output logic [15:0] rd2
);
  logic [15:0] rf [8];

  // write port; asynchronous clear to RF_INIT
  always_ff @(posedge clk or negedge reset)
    if (!reset) for (int i = 0; i < 8; i++) rf[i] <= RF_INIT;
    else if (we) rf[waddr] <= wdata;

  // reads return the in-flight write value when addresses match
  always_comb begin
    rd1 = (we && ra1 == waddr) ? wdata : rf[ra1];
    rd2 = (we && ra2 == waddr) ? wdata : rf[ra2];
  end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: LC-3 write-back stage retiring instructions into RF, CC, PSR and counter
module wb_stage
  import lc3_pkg::*;
#(
  parameter logic [15:0] RF_INIT  = 16'h0000,
  parameter logic [15:0] PSR_INIT = PSR_INIT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] wbIRin,
  input  logic [15:0] wbNPCin,
  input  logic [15:0] wbData,
  input  logic [15:0] wbPCin,
  input  logic        wbCond,
  input  logic [15:0] wbPSRin,
  input  logic        wbValid,
  input  logic [2:0]  idSR1,
  input  logic [2:0]  idSR2,
  output logic [15:0] idSR1data,
  output logic [15:0] idSR2data,
  output logic        wbN,
  output logic        wbZ,
  output logic        wbP,
  output logic [15:0] wbPSR,
  output logic        wbRedirect,
  output logic [15:0] wbTarget,
  output logic [15:0] wbInstret
);
  logic [3:0]  op;
  logic [5:0]  fn;
  logic        retire, we, cc_ld, psr_ld, redir_req;
  logic [2:0]  waddr, cc;
  logic [15:0] wdata, psr_val;
  logic [15:3] psr_hi;

  assign op = wbIRin[15:12];
  assign fn = wbIRin[5:0];
  assign retire = wbValid && wbIRin != NOP_IR;
  assign redir_req = retire && wbCond && (op == OP_TRAP || op == OP_RTI);
  assign {wbN, wbZ, wbP} = cc;
  assign wbPSR = {psr_hi, cc};

  // decode retirement side effects of the incoming instruction
  always_comb begin
    we = 1'b0;
    waddr = wbIRin[11:9];
    wdata = wbData;
    cc_ld = 1'b0;
    psr_ld = 1'b0;
    psr_val = wbData;
    if (retire)
      case (op)
        OP_ADD, OP_AND, OP_LD, OP_LDR, OP_LDI: begin we = 1'b1; cc_ld = 1'b1; end
        OP_NOT:
          if (fn == FN_WPS) psr_ld = 1'b1;
          else if (fn != FN_NOP) begin we = 1'b1; cc_ld = 1'b1; end
        OP_LEA: we = 1'b1;
        OP_JSR, OP_TRAP: begin we = 1'b1; waddr = 3'd7; wdata = wbNPCin; end
        OP_RTI:
          if (!wbCond) begin we = 1'b1; waddr = 3'd6; psr_ld = 1'b1; psr_val = wbPSRin; end
        default: ;
      endcase
  end

  // PSR/CC state; a PSR load also reloads CC from its low bits
  always_ff @(posedge clk or negedge reset)
    if (!reset) {psr_hi, cc} <= PSR_INIT;
    else if (psr_ld) {psr_hi, cc} <= psr_val;
    else if (cc_ld) cc <= cc_of(wbData);

  // redirect pulse (self-clearing so it lasts one cycle) and retire counter
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wbRedirect <= 1'b0;
      wbTarget <= 16'h0;
      wbInstret <= 16'h0;
    end else begin
      wbRedirect <= redir_req && !wbRedirect;
      wbTarget <= wbPCin;
      if (retire) wbInstret <= wbInstret + 16'd1;
    end

  wb_regfile #(.RF_INIT(RF_INIT)) u_rf (
    .clk(clk),
    .reset(reset),
    .we(we),
    .waddr(waddr),
    .wdata(wdata),
    .ra1(idSR1),
    .ra2(idSR2),
    .rd1(idSR1data),
    .rd2(idSR2data)
  );
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed self-checking bench for wb_stage
module tb_wb_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] wbIRin = 16'h9000, wbNPCin = 16'h0, wbData = 16'h0, wbPCin = 16'h0, wbPSRin = 16'h0;
  logic        wbCond = 1'b0, wbValid = 1'b1;
  logic [2:0]  idSR1 = 3'd0, idSR2 = 3'd0;
  logic [15:0] idSR1data, idSR2data, wbPSR, wbTarget, wbInstret;
  logic        wbN, wbZ, wbP, wbRedirect;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .reset(reset), .wbIRin(wbIRin), .wbNPCin(wbNPCin), .wbData(wbData),
    .wbPCin(wbPCin), .wbCond(wbCond), .wbPSRin(wbPSRin), .wbValid(wbValid),
    .idSR1(idSR1), .idSR2(idSR2), .idSR1data(idSR1data), .idSR2data(idSR2data),
    .wbN(wbN), .wbZ(wbZ), .wbP(wbP), .wbPSR(wbPSR), .wbRedirect(wbRedirect),
    .wbTarget(wbTarget), .wbInstret(wbInstret)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // inputs change on the falling edge, away from the sampling edge
  task automatic drive(input logic [15:0] ir, input logic [15:0] npc, input logic [15:0] data,
                       input logic [15:0] pc, input logic cond, input logic [15:0] psr, input logic valid);
    @(negedge clk);
    wbIRin = ir; wbNPCin = npc; wbData = data; wbPCin = pc;
    wbCond = cond; wbPSRin = psr; wbValid = valid;
    #1;
  endtask

  task automatic edge1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_psr", wbPSR, 16'h8002);
    chk("rst_cc", {13'h0, wbN, wbZ, wbP}, 16'h0002);
    chk("rst_instret", wbInstret, 16'h0);
    chk("rst_redirect", {15'h0, wbRedirect}, 16'h0);
    chk("rst_target", wbTarget, 16'h0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      idSR1 = i[2:0];
      #1 chk("rst_rf", idSR1data, 16'h0);
    end
    // ADD R3 with negative result, bypassed read in the same cycle
    drive(16'h1642, 16'h3000, 16'hFFFE, 16'h0, 1'b0, 16'h0, 1'b1);
    idSR1 = 3'd3;
    #1 chk("add_bypass", idSR1data, 16'hFFFE);
    edge1();
    chk("add_cc", {13'h0, wbN, wbZ, wbP}, 16'h0004);
    chk("add_instret", wbInstret, 16'h1);
    drive(16'h9000, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b1);
    chk("add_r3", idSR1data, 16'hFFFE);
    // LDI R2: pause beat must be ignored, final beat writes zero
    drive(16'hA5FF, 16'h3001, 16'h1234, 16'h0, 1'b0, 16'h0, 1'b0);
    idSR2 = 3'd2;
    #1 chk("ldi_pause_nobypass", idSR2data, 16'h0);
    edge1();
    chk("ldi_pause_r2", idSR2data, 16'h0);
    chk("ldi_pause_instret", wbInstret, 16'h1);
    chk("ldi_pause_cc", {13'h0, wbN, wbZ, wbP}, 16'h0004);
    drive(16'hA5FF, 16'h3001, 16'h0000, 16'h0, 1'b0, 16'h0, 1'b1);
    edge1();
    chk("ldi_cc", {13'h0, wbN, wbZ, wbP}, 16'h0002);
    chk("ldi_instret", wbInstret, 16'h2);
    // TRAP held for two cycles: pulse must still be exactly one cycle
    drive(16'hF025, 16'h3001, 16'h0, 16'h0520, 1'b1, 16'h0, 1'b1);
    edge1();
    chk("trap_redirect", {15'h0, wbRedirect}, 16'h1);
    chk("trap_target", wbTarget, 16'h0520);
    chk("trap_instret", wbInstret, 16'h3);
    edge1();
    chk("trap_no_stretch", {15'h0, wbRedirect}, 16'h0);
    chk("trap2_instret", wbInstret, 16'h4);
    drive(16'h9000, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b1);
    idSR2 = 3'd7;
    #1 chk("trap_r7", idSR2data, 16'h3001);
    edge1();
    chk("nop_redirect", {15'h0, wbRedirect}, 16'h0);
    chk("trap_cc_kept", {13'h0, wbN, wbZ, wbP}, 16'h0002);
    // RTI beat 1: redirect only
    drive(16'h8000, 16'h0, 16'h5555, 16'h4000, 1'b1, 16'h7777, 1'b1);
    idSR1 = 3'd6;
    edge1();
    chk("rti1_redirect", {15'h0, wbRedirect}, 16'h1);
    chk("rti1_target", wbTarget, 16'h4000);
    chk("rti1_r6", idSR1data, 16'h0);
    chk("rti1_psr", wbPSR, 16'h8002);
    // RTI beat 2: R6, PSR and CC restored
    drive(16'h8000, 16'h0, 16'h3000, 16'h4000, 1'b0, 16'h0001, 1'b1);
    chk("rti2_bypass", idSR1data, 16'h3000);
    edge1();
    chk("rti2_redirect", {15'h0, wbRedirect}, 16'h0);
    chk("rti2_psr", wbPSR, 16'h0001);
    chk("rti2_cc", {13'h0, wbN, wbZ, wbP}, 16'h0001);
    chk("rti2_instret", wbInstret, 16'h6);
    // LEA R1 leaves CC alone
    drive(16'hE200, 16'h0, 16'h8000, 16'h0, 1'b0, 16'h0, 1'b1);
    edge1();
    chk("lea_cc", {13'h0, wbN, wbZ, wbP}, 16'h0001);
    drive(16'h9000, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b1);
    idSR1 = 3'd1;
    #1 chk("lea_r1", idSR1data, 16'h8000);
    // WPS loads PSR without touching R0
    drive(16'h9022, 16'h0, 16'h8004, 16'h0, 1'b0, 16'h0, 1'b1);
    edge1();
    chk("wps_psr", wbPSR, 16'h8004);
    chk("wps_cc", {13'h0, wbN, wbZ, wbP}, 16'h0004);
    chk("wps_instret", wbInstret, 16'h8);
    drive(16'h9000, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b1);
    idSR1 = 3'd0;
    #1 chk("wps_r0", idSR1data, 16'h0);
    // run the counter to FFFF, then wrap
    drive(16'h1021, 16'h0, 16'h0001, 16'h0, 1'b0, 16'h0, 1'b1);
    repeat (65527) @(posedge clk);
    #1 chk("instret_max", wbInstret, 16'hFFFF);
    edge1();
    chk("instret_wrap", wbInstret, 16'h0000);
    // reset between RTI beats
    drive(16'h8000, 16'h0, 16'h0, 16'h4000, 1'b1, 16'h0, 1'b1);
    edge1();
    chk("rti_mid_redirect", {15'h0, wbRedirect}, 16'h1);
    @(negedge clk);
    reset = 1'b0;
    idSR1 = 3'd1;
    idSR2 = 3'd7;
    #1;
    chk("arst_redirect", {15'h0, wbRedirect}, 16'h0);
    chk("arst_target", wbTarget, 16'h0);
    chk("arst_instret", wbInstret, 16'h0);
    chk("arst_psr", wbPSR, 16'h8002);
    chk("arst_r1", idSR1data, 16'h0);
    chk("arst_r7", idSR2data, 16'h0);
    drive(16'h9000, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b1);
    reset = 1'b1;
    edge1();
    chk("post_rst_instret", wbInstret, 16'h0);
    chk("post_rst_cc", {13'h0, wbN, wbZ, wbP}, 16'h0002);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
